// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared types and constants for the UART transmit arbiter
//
// Purpose: arbiter FSM state type, default end-of-message character and the
//          width of the per-message character counter.
// Ports:   none (package).
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic [7:0] EOM_CHAR_DEFAULT = 8'h0A;
  localparam int         COUNT_W          = 8;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// rtl/uart_tx_rr_pick.sv - combinational round-robin winner picker
//
// Purpose: returns the first set request strictly after last_i, wrapping
//          from N-1 back to 0. Generic so other shared-resource arbiters can
//          reuse it.
// Ports:
//   req_i    in  N  request vector
//   last_i   in  W  index of the previous winner
//   idx_o    out W  winning index (0 when no request)
//   valid_o  out 1  at least one request is set
module uart_tx_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [W-1:0] j;

  // Scan offsets from farthest to nearest so the nearest requester after
  // last_i is the final one written and therefore wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last_i) + k) % N);
      if (req_i[j]) begin
        idx_o   = j;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - message-atomic round-robin arbiter in front of the UART transmitter
//
// Purpose: shares one UART transmitter between NUM_REQ FWFT character
//          sources. A grant lasts a whole message (ended by EOM_CHAR or by
//          MAX_MSG_LEN characters) so lines from different sources never
//          interleave. A one-entry hold register drives the FWFT output.
// Optional: UART_TX_ARB_IDLE_TIMEOUT_EN adds a stall counter that forces
//          release after IDLE_TIMEOUT empty cycles and pulses abort_pulse.
// Ports:
//   clk_tx           in  1          transmit-domain clock
//   rst_n_clk_tx     in  1          synchronous active-low reset
//   req_empty        in  NUM_REQ    per-source FWFT empty
//   req_dout         in  8*NUM_REQ  per-source FWFT data, source i at [8i+7:8i]
//   req_rd_en        out NUM_REQ    per-source pop, one-hot or zero
//   char_fifo_empty  out 1          FWFT empty toward the transmitter
//   char_fifo_dout   out 8          FWFT data toward the transmitter
//   char_fifo_rd_en  in  1          pop from the transmitter
//   grant_id         out clog2(NUM_REQ) current/last granted source
//   busy             out 1          grant held
//   abort_pulse      out 1          stall-timeout release (optional build only)
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter logic [7:0] EOM_CHAR    = EOM_CHAR_DEFAULT,
  parameter int         MAX_MSG_LEN = 64
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
  , parameter int       IDLE_TIMEOUT = 4096
`endif
) (
  input  logic                       clk_tx,
  input  logic                       rst_n_clk_tx,
  input  logic [NUM_REQ-1:0]         req_empty,
  input  logic [8*NUM_REQ-1:0]       req_dout,
  output logic [NUM_REQ-1:0]         req_rd_en,
  output logic                       char_fifo_empty,
  output logic [7:0]                 char_fifo_dout,
  input  logic                       char_fifo_rd_en,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
  , output logic                     abort_pulse
`endif
);

  localparam int GW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               hold_valid_q, hold_valid_d;
  logic [7:0]         hold_data_q, hold_data_d;

  logic               hold_free;
  logic               cur_empty;
  logic [7:0]         cur_data;
  logic               pop;
  logic               msg_end;
  logic [GW-1:0]      pick_idx;
  logic               pick_valid;

`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
  localparam int SW = $clog2(IDLE_TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          abort_q, abort_d;
  assign abort_pulse = abort_q;
`endif

  uart_tx_rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req_i   (~req_empty),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // A pop and an output drain may share a cycle, giving 1 char/cycle.
  assign hold_free = !hold_valid_q | char_fifo_rd_en;
  assign cur_empty = req_empty[grant_q];
  assign cur_data  = req_dout[{grant_q, 3'b000} +: 8];
  assign pop       = (state_q == XFER) & hold_free & !cur_empty;
  // Compare against MAX_MSG_LEN-1 so the 8-bit count never has to hold 256.
  assign msg_end   = (cur_data == EOM_CHAR) ||
                     (count_q == COUNT_W'(MAX_MSG_LEN - 1));

  always_ff @(posedge clk_tx) begin
    if (!rst_n_clk_tx) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= GW'(NUM_REQ - 1);
      count_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
      stall_q      <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      count_q      <= count_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
      stall_q      <= stall_d;
      abort_q      <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    count_d      = count_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
    stall_d      = '0;
    abort_d      = 1'b0;
`endif

    // Drain first; a same-cycle load below overrides it.
    if (char_fifo_rd_en) hold_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          count_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          hold_valid_d = 1'b1;
          hold_data_d  = cur_data;
          count_d      = count_q + 1'b1;
          if (msg_end) state_d = IDLE;
        end
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
        else if (cur_empty) begin
          if (stall_q == SW'(IDLE_TIMEOUT - 1)) begin
            state_d = IDLE;
            abort_d = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rd_en = '0;
    if (pop) req_rd_en[grant_q] = 1'b1;
  end

  assign busy            = (state_q == XFER);
  assign grant_id        = grant_q;
  assign char_fifo_empty = !hold_valid_q;
  assign char_fifo_dout  = hold_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

  localparam int N    = 4;
  localparam int MAXL = 64;

  logic             clk_tx = 1'b0;
  logic             rst_n_clk_tx;
  logic [N-1:0]     req_empty;
  logic [8*N-1:0]   req_dout;
  logic [N-1:0]     req_rd_en;
  logic             char_fifo_empty;
  logic [7:0]       char_fifo_dout;
  logic             char_fifo_rd_en;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
  logic             abort_pulse;
`endif

  always #5 clk_tx = ~clk_tx;

  uart_tx_arb #(.NUM_REQ(N), .MAX_MSG_LEN(MAXL)) dut (
    .clk_tx          (clk_tx),
    .rst_n_clk_tx    (rst_n_clk_tx),
    .req_empty       (req_empty),
    .req_dout        (req_dout),
    .req_rd_en       (req_rd_en),
    .char_fifo_empty (char_fifo_empty),
    .char_fifo_dout  (char_fifo_dout),
    .char_fifo_rd_en (char_fifo_rd_en),
    .grant_id        (grant_id),
    .busy            (busy)
`ifdef UART_TX_ARB_IDLE_TIMEOUT_EN
    , .abort_pulse   (abort_pulse)
`endif
  );

  logic [7:0] mem [N][512];
  int         head [N];
  int         tail [N];
  logic [7:0] exp_q [$];
  logic [N-1:0] rd_cap;
  int         rd_mode;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      req_empty[i]      = (head[i] == tail[i]);
      req_dout[8*i +: 8] = mem[i][head[i]];
    end
  endtask

  task automatic load(input int s, input logic [7:0] c);
    mem[s][tail[s]] = c;
    tail[s]++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      for (int k = 0; k < 512; k++) mem[i][k] = 8'h00;
    end
    exp_q.delete();
  endtask

  // Message-level reference: serve non-empty sources in rotating order
  // starting after source N-1; each turn takes chars up to and including
  // 0A, at most MAXL of them.
  function automatic void build_model();
    int mh [N];
    int last;
    int w;
    int n;
    logic [7:0] c;
    for (int i = 0; i < N; i++) mh[i] = head[i];
    last = N - 1;
    while (1) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && mh[(last + k) % N] < tail[(last + k) % N]) w = (last + k) % N;
      if (w < 0) break;
      last = w;
      n = 0;
      do begin
        c = mem[w][mh[w]];
        mh[w]++;
        exp_q.push_back(c);
        n++;
      end while (c != 8'h0A && n < MAXL && mh[w] < tail[w]);
    end
  endfunction

  task automatic sample();
    rd_cap = rst_n_clk_tx ? req_rd_en : '0;
    if (req_rd_en != '0) begin
      chk("rd_onehot", 32'($onehot(req_rd_en)), 32'd1);
      chk("rd_of_empty", 32'(|(req_rd_en & req_empty)), 32'd0);
      chk("rd_while_busy", 32'(busy), 32'd1);
    end
    if (rst_n_clk_tx && !char_fifo_empty && char_fifo_rd_en) begin
      if (exp_q.size() == 0) chk("out_unexpected", 32'(char_fifo_dout), 32'h100);
      else chk("out_char", 32'(char_fifo_dout), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic cyc();
    @(posedge clk_tx);
    #1;
    for (int i = 0; i < N; i++) if (rd_cap[i]) head[i]++;
    refresh();
    case (rd_mode)
      0:       char_fifo_rd_en = 1'b0;
      1:       char_fifo_rd_en = 1'b1;
      default: char_fifo_rd_en = ($urandom_range(0, 9) < 7);
    endcase
    @(negedge clk_tx);
    sample();
  endtask

  task automatic do_reset();
    rst_n_clk_tx    = 1'b0;
    rd_mode         = 0;
    char_fifo_rd_en = 1'b0;
    cyc();
    cyc();
    clear_all();
    refresh();
    rd_cap = '0;
  endtask

  task automatic run_done(input string tag, input int budget);
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && char_fifo_empty && !busy) && t < budget) begin
      cyc();
      t++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n_clk_tx    = 1'b0;
    char_fifo_rd_en = 1'b0;
    rd_mode         = 0;
    rd_cap          = '0;
    req_empty       = '1;
    req_dout        = '0;
    clear_all();
    refresh();
    @(negedge clk_tx);
    do_reset();

    // reset state
    chk("rst_empty", 32'(char_fifo_empty), 32'd1);
    chk("rst_dout", 32'(char_fifo_dout), 32'h00);
    chk("rst_rd_en", 32'(req_rd_en), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // "AB\n" from source 0 with the transmitter always ready
    load(0, 8'h41); load(0, 8'h42); load(0, 8'h0A);
    refresh(); build_model();
    rd_mode = 1; char_fifo_rd_en = 1'b1; rst_n_clk_tx = 1'b1;
    cyc();
    chk("t1_busy_arb", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd0);
    chk("t1_empty_arb", 32'(char_fifo_empty), 32'd1);
    cyc();
    chk("t1_c0", 32'(char_fifo_dout), 32'h41);
    chk("t1_c0_valid", 32'(char_fifo_empty), 32'd0);
    cyc();
    chk("t1_c1", 32'(char_fifo_dout), 32'h42);
    cyc();
    chk("t1_c2", 32'(char_fifo_dout), 32'h0A);
    chk("t1_busy_end", 32'(busy), 32'd0);
    run_done("t1", 50);

    // sources 1 and 2 both hold "X\n"
    do_reset();
    load(1, 8'h58); load(1, 8'h0A); load(2, 8'h58); load(2, 8'h0A);
    refresh(); build_model();
    rd_mode = 1; char_fifo_rd_en = 1'b1; rst_n_clk_tx = 1'b1;
    cyc();
    chk("t2_grant1", 32'(grant_id), 32'd1);
    cyc();
    chk("t2_s1_x", 32'(char_fifo_dout), 32'h58);
    cyc();
    chk("t2_s1_eom", 32'(char_fifo_dout), 32'h0A);
    chk("t2_idle_gap", 32'(busy), 32'd0);
    cyc();
    chk("t2_busy_again", 32'(busy), 32'd1);
    chk("t2_grant2", 32'(grant_id), 32'd2);
    chk("t2_gap_empty", 32'(char_fifo_empty), 32'd1);
    cyc();
    chk("t2_s2_x", 32'(char_fifo_dout), 32'h58);
    run_done("t2", 50);

    // source 3 streams 70 chars without 0A, source 0 arrives mid-message
    do_reset();
    for (int k = 0; k < 70; k++) load(3, 8'(8'h20 + (k % 50)));
    load(3, 8'h0A);
    for (int k = 0; k < 64; k++) exp_q.push_back(mem[3][k]);
    exp_q.push_back(8'h51); exp_q.push_back(8'h0A);
    for (int k = 64; k < 71; k++) exp_q.push_back(mem[3][k]);
    refresh();
    rd_mode = 1; char_fifo_rd_en = 1'b1; rst_n_clk_tx = 1'b1;
    cyc();
    chk("t3_grant3", 32'(grant_id), 32'd3);
    for (int k = 0; k < 4; k++) cyc();
    load(0, 8'h51); load(0, 8'h0A);
    run_done("t3", 400);
    chk("t3_s3_consumed", 32'(head[3]), 32'd71);

    // transmitter stalled: exactly one char pulled into the hold register
    do_reset();
    load(0, 8'h41); load(0, 8'h42); load(0, 8'h0A);
    refresh(); build_model();
    rd_mode = 0; rst_n_clk_tx = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    chk("t4_one_pop", 32'(head[0]), 32'd1);
    chk("t4_held", 32'(char_fifo_empty), 32'd0);
    chk("t4_held_data", 32'(char_fifo_dout), 32'h41);
    chk("t4_no_rd", 32'(req_rd_en), 32'd0);
    rd_mode = 1;
    cyc();
    chk("t4_resume0", 32'(char_fifo_dout), 32'h41);
    cyc();
    chk("t4_resume1", 32'(char_fifo_dout), 32'h42);
    cyc();
    chk("t4_resume2", 32'(char_fifo_dout), 32'h0A);
    run_done("t4", 50);

    // reset mid-message with a char held
    do_reset();
    load(0, 8'h48); load(0, 8'h45); load(0, 8'h4C); load(0, 8'h4F); load(0, 8'h0A);
    load(1, 8'h5A); load(1, 8'h0A);
    refresh();
    rd_mode = 0; rst_n_clk_tx = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    rst_n_clk_tx = 1'b0;
    cyc();
    chk("t5_rst_empty", 32'(char_fifo_empty), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_grant", 32'(grant_id), 32'd0);
    chk("t5_rst_rd", 32'(req_rd_en), 32'd0);
    exp_q.delete();
    build_model();
    rd_mode = 1; rst_n_clk_tx = 1'b1;
    cyc();
    chk("t5_first_grant", 32'(grant_id), 32'd0);
    run_done("t5", 100);

    // randomized traffic against the message-level model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int s = 0; s < N; s++) begin
        int len;
        logic [7:0] c;
        len = $urandom_range(0, 90);
        for (int k = 0; k < len; k++) begin
          c = 8'($urandom);
          if ($urandom_range(0, 9) == 0) c = 8'h0A;
          load(s, c);
        end
        if (len > 0) load(s, 8'h0A);
      end
      refresh(); build_model();
      rd_mode = 2; rst_n_clk_tx = 1'b1;
      run_done("rand", 3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Message-atomic round-robin arbiter that shares the single UART transmitter between NUM_REQ character sources. Each source presents a FWFT character interface (empty/dout/rd_en). The block presents one FWFT character interface to the UART transmitter's char FIFO port. A grant is held for a whole message, terminated by EOM_CHAR or by MAX_MSG_LEN characters, so output lines from different sources never interleave.

Parameters:
NUM_REQ, 4, number of requesting character sources (2..8)
EOM_CHAR, 8'h0A, end-of-message character; the grant is released after it is forwarded
MAX_MSG_LEN, 64, maximum characters per grant; forced release when reached (1..255)
IDLE_TIMEOUT, 4096, stall cycles before forced release (optional feature only)

Ports:
clk_tx  in  1  transmit-domain clock
rst_n_clk_tx  in  1  reset, synchronous to clk_tx, active LOW
req_empty  in  NUM_REQ  per-source FWFT empty
req_dout  in  8*NUM_REQ  per-source FWFT data; source i occupies bits [8i+7:8i]
req_rd_en  out  NUM_REQ  per-source pop, one-hot or zero
char_fifo_empty  out  1  FWFT empty toward the UART transmitter
char_fifo_dout  out  8  FWFT data toward the UART transmitter
char_fifo_rd_en  in  1  pop from the UART transmitter
grant_id  out  clog2(NUM_REQ)  current/last granted source
busy  out  1  high while a grant is held (state XFER)

Behaviour:
- Reset (rst_n_clk_tx low at a clk_tx edge): state=IDLE, char_fifo_empty=1, char_fifo_dout=8'h00, req_rd_en=0, grant_id=0, busy=0, msg count=0, RR last pointer=NUM_REQ-1 so source 0 wins first. Reset mid-message discards the held character. Characters already popped from a source are not replayed.
- Output stage: one-entry hold register. char_fifo_empty = !hold_valid and char_fifo_dout = hold_data, both registered. char_fifo_rd_en while char_fifo_empty=1 is ignored.
- hold_free = !hold_valid | char_fifo_rd_en. A pop and a load in the same cycle is legal: a full-throughput pass-through of 1 char/cycle.
- FSM states:
  IDLE: if any req_empty[i]==0, pick the first non-empty source after the RR last pointer (wrapping NUM_REQ-1 to 0). Register grant_id and the last pointer, clear count, go to XFER the next cycle. If no source is non-empty, stay in IDLE.
  XFER: req_rd_en[grant_id] = hold_free & !req_empty[grant_id], combinational. On a pop, hold_data<=req_dout[grant_id], hold_valid<=1, count<=count+1. If the popped char == EOM_CHAR or count+1 == MAX_MSG_LEN, go to IDLE. A pop while hold_free=0 never occurs.
- Latency: a source's first character is visible on char_fifo_dout 2 cycles after its req_empty falls while in IDLE: 1 cycle arbitration, 1 cycle load.
- Back-to-back grants: 1 idle cycle in IDLE between messages. The hold register may still be draining during arbitration.
- Granted source empty mid-message: grant held indefinitely and other sources wait (base build).
- Only the granted source is ever popped. req_rd_en is never asserted in IDLE.
- count width: 8 bits, no wrap, because release occurs at MAX_MSG_LEN.

Optional Feature:
Macro UART_TX_ARB_IDLE_TIMEOUT_EN.
- Defined: a stall counter in XFER increments each cycle req_empty[grant_id]==1 and clears on a pop. When it reaches IDLE_TIMEOUT, force IDLE and pulse output abort_pulse (1 cycle, reset 0). Held data is still delivered.
- Undefined: no counter, no abort_pulse port, grant held until EOM or MAX_MSG_LEN.

Decomposition:
- Package uart_tx_arb_pkg contains:
  - state enum {IDLE, XFER}
  - default EOM_CHAR constant
  - count width constant (8)
- Sub-module uart_tx_rr_pick: combinational round-robin picker, inputs request vector and last pointer, outputs winner index and valid. Reused by future shared-resource arbiters.

Test Plan:
- Reset, then source 0 holds "AB\n" (41,42,0A) with char_fifo_rd_en tied 1 -> dout sequence 41,42,0A on consecutive cycles starting 2 cycles after reset release; grant_id=0; busy drops after 0A popped.
- Sources 1 and 2 both hold "X\n" -> source 1 served fully first, then source 2. No interleaving; exactly 1 IDLE cycle between messages.
- Source 3 streams 70 chars with no 0A, MAX_MSG_LEN=64 -> release after the 64th char; rotates to another pending source; source 3 resumes later with char 65.
- char_fifo_rd_en held 0 with source 0 pending -> exactly one pop, char_fifo_empty=0, req_rd_en stays 0; raising rd_en resumes 1 char/cycle.
- Reset asserted mid-message with char held -> next cycle char_fifo_empty=1, busy=0, grant_id=0; after release, source 0 wins first.
- With UART_TX_ARB_IDLE_TIMEOUT_EN, IDLE_TIMEOUT=16: source 0 sends "A" then stalls while source 1 pending -> abort_pulse after 16 stall cycles; source 1 is granted next.
